// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one 4:1-muxed resource among four requesters.
// Latency: req -> registered one-hot grant/sel one cycle later; one idle cycle between grants.
// Backpressure: the grant is held until ack or until the owner withdraws req; others wait.
//
// Ports:
//   clk      in   1  clock, all state on rising edge
//   reset    in   1  asynchronous, active-high reset
//   req      in   4  level-held request per requester
//   ack      in   1  one-cycle "transaction done" pulse from the shared resource
//   grant    out  4  registered one-hot grant, 4'b0000 when idle
//   sel      out  2  registered mux select (index of granted requester), holds in idle
//   busy     out  1  high while a grant is outstanding
//   timeout  out  1  one-cycle pulse on a watchdog-forced release (0 unless enabled)
//
// Optional feature: define ARB_TIMEOUT_EN to build the grant watchdog
// (parameters TIMEOUT_CYCLES, CNT_WIDTH exist only in that build).
module mux4_rr_arbiter
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;

    logic [1:0] winner_c;
    logic       force_c;
    logic       release_c;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // Rotating priority scan: first set request at ptr, ptr+1, ... (mod 4).
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner_c = ptr_q;
        found    = 1'b0;
        idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                winner_c = idx;
                found    = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // cnt_q counts completed GRANT cycles, so the TIMEOUT_CYCLES-th cycle forces release.
    assign force_c = (state_q == GRANT) && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign force_c = 1'b0;
`endif

    // A drop of the owner's request, an ack, or the watchdog all release the same way.
    assign release_c = ack || !req[sel_q] || force_c;

    // State register (plus the registered outputs it qualifies).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req)     state_d = GRANT;
            GRANT:   if (release_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                if (|req) begin
                    grant_d = 4'b0001 << winner_c;
                    sel_d   = winner_c;
                end
            end
            GRANT: begin
                if (release_c) begin
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    // A genuine release in the same cycle takes precedence over the watchdog.
                    timeout_d = force_c && !ack && req[sel_q];
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: grant_d = 4'b0000;
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: hand-computed grant/sel/busy/timeout per step.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int passes = 0;

`ifdef ARB_TIMEOUT_EN
    mux4_rr_arbiter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
`else
    mux4_rr_arbiter dut (
`endif
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .ack     (ack),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic t);
        chk({tag, ".grant"},   grant,            g);
        chk({tag, ".sel"},     {2'b00, sel},     {2'b00, s});
        chk({tag, ".busy"},    {3'b000, busy},   {3'b000, b});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, t});
    endtask

    logic [3:0] rr_grant [5];
    logic [1:0] rr_sel   [5];

    initial begin
        rr_grant[0] = 4'b0001; rr_grant[1] = 4'b0010; rr_grant[2] = 4'b0100;
        rr_grant[3] = 4'b1000; rr_grant[4] = 4'b0001;
        rr_sel[0] = 2'd0; rr_sel[1] = 2'd1; rr_sel[2] = 2'd2; rr_sel[3] = 2'd3; rr_sel[4] = 2'd0;

        // Reset held with all requests high: nothing granted.
        reset = 1'b1; req = 4'b1111; ack = 1'b0;
        tick;
        chk_state("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick;
        chk_state("rst_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick;
        chk_state("rst_release", 4'b0001, 2'd0, 1'b1, 1'b0);
        // Withdraw releases; sel holds its value in idle. ptr -> 1.
        req = 4'b0000;
        tick;
        chk_state("withdraw0", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester 2, one-cycle latency, other req changes ignored.
        req = 4'b0100;
        tick;
        chk_state("r2_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0111;
        tick;
        chk_state("r2_c2_frozen", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick;
        ack = 1'b1;
        tick;
        ack = 1'b0; req = 4'b0000;
        chk_state("r2_ack_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        // ack in IDLE is ignored. ptr = 3.
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk_state("idle_ack", 4'b0000, 2'd2, 1'b0, 1'b0);

        // ptr=3 picks requester 3 over 0; ack + drop together release once; ptr wraps to 0.
        req = 4'b1001;
        tick;
        chk_state("wrap_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0001; ack = 1'b1;
        tick;
        ack = 1'b0;
        chk_state("ack_drop_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick;
        chk_state("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick;
        chk("wrap_idle", grant, 4'b0000);

        // Full rotation with all requests held, ack two cycles after each grant.
        reset = 1'b1;
        tick;
        reset = 1'b0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk_state($sformatf("rr%0d_grant", k), rr_grant[k], rr_sel[k], 1'b1, 1'b0);
            tick;
            chk($sformatf("rr%0d_hold", k), grant, rr_grant[k]);
            ack = 1'b1;
            tick;
            ack = 1'b0;
            chk_state($sformatf("rr%0d_idle", k), 4'b0000, rr_sel[k], 1'b0, 1'b0);
        end
        req = 4'b0000;
        tick;

        // Requester 1 withdraws; ptr=2 makes requester 3 win over 0.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req = 4'b0010;
        tick;
        chk_state("wd_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1001;
        tick;
        chk_state("wd_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick;
        chk_state("wd_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick;
        chk("wd_idle", grant, 4'b0000);

        // Move ptr to 2, then reset mid-GRANT: clears at once and ptr returns to 0.
        req = 4'b0010;
        tick;
        chk("pre_g1", grant, 4'b0010);
        ack = 1'b1;
        tick;
        ack = 1'b0; req = 4'b1000;
        tick;
        chk_state("mid_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick;
        reset = 1'b0; req = 4'b1001;
        tick;
        chk_state("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick;
        req = 4'b1000;
        tick;
        chk_state("post_rst_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick;

        // Grant with no ack: watchdog release if built, otherwise held indefinitely.
        req = 4'b0010;
        tick;
        chk_state("to_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_state($sformatf("to_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick;
        chk_state("to_fire", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick;
        chk_state("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 120; i++) begin
            tick;
            chk($sformatf("hold%0d.grant", i), grant, 4'b0010);
            chk($sformatf("hold%0d.timeout", i), {3'b000, timeout}, 4'b0000);
        end
`endif
        req = 4'b0000;
        tick;
        chk_state("final_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
